// File: rtl/minicpu_pkg.sv
// minicpu_pkg: shared types and encodings for the multi-cycle miniCPU core.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package minicpu_pkg;

  localparam logic [31:0] RESET_PC_DEF = 32'h1c000000;

  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_EX   = 3'd1,
    S_MEM  = 3'd2,
    S_WB   = 3'd3,
    S_HALT = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    ALU_ADD = 2'd0,
    ALU_SUB = 2'd1,
    ALU_LUI = 2'd2
  } alu_op_e;

  typedef enum logic [1:0] {
    BR_NONE = 2'd0,
    BR_EQ   = 2'd1,
    BR_NE   = 2'd2,
    BR_B    = 2'd3
  } br_type_e;

  // Opcode fields, each compared against the IR slice named in its comment
  localparam logic [16:0] OP_ADD_W   = 17'h00020; // ir[31:15]
  localparam logic [16:0] OP_SUB_W   = 17'h00022; // ir[31:15]
  localparam logic [9:0]  OP_ADDI_W  = 10'h00A;   // ir[31:22]
  localparam logic [6:0]  OP_LU12I_W = 7'h0A;     // ir[31:25]
  localparam logic [9:0]  OP_LD_W    = 10'h0A2;   // ir[31:22]
  localparam logic [9:0]  OP_ST_W    = 10'h0A6;   // ir[31:22]
  localparam logic [5:0]  OP_BEQ     = 6'h16;     // ir[31:26]
  localparam logic [5:0]  OP_BNE     = 6'h17;     // ir[31:26]
  localparam logic [5:0]  OP_B       = 6'h14;     // ir[31:26]

  // Sign-extend the 12-bit immediate used by addi.w/ld.w/st.w
  function automatic logic [31:0] sext12(input logic [11:0] v);
    return {{20{v[11]}}, v};
  endfunction

endpackage

// File: rtl/minicpu_decoder.sv
// minicpu_decoder: instruction word -> control bundle.
// Latency: purely combinational.
// Backpressure: none; output follows ir.
module minicpu_decoder
  import minicpu_pkg::*;
(
  input  logic [31:0] ir,
  output alu_op_e     alu_op,
  output logic        src2_is_imm,
  output logic        src_reg_is_rd,
  output logic        gr_we,
  output logic        mem_rd,
  output logic        mem_we,
  output br_type_e    br_type,
  output logic        illegal
);

  // Match opcode fields; anything unmatched is flagged illegal with no side effects
  always_comb begin
    alu_op        = ALU_ADD;
    src2_is_imm   = 1'b0;
    src_reg_is_rd = 1'b0;
    gr_we         = 1'b0;
    mem_rd        = 1'b0;
    mem_we        = 1'b0;
    br_type       = BR_NONE;
    illegal       = 1'b0;
    if (ir[31:15] == OP_ADD_W) begin
      gr_we = 1'b1;
    end else if (ir[31:15] == OP_SUB_W) begin
      alu_op = ALU_SUB;
      gr_we  = 1'b1;
    end else if (ir[31:22] == OP_ADDI_W) begin
      src2_is_imm = 1'b1;
      gr_we       = 1'b1;
    end else if (ir[31:25] == OP_LU12I_W) begin
      alu_op      = ALU_LUI;
      src2_is_imm = 1'b1;
      gr_we       = 1'b1;
    end else if (ir[31:22] == OP_LD_W) begin
      src2_is_imm = 1'b1;
      gr_we       = 1'b1;
      mem_rd      = 1'b1;
    end else if (ir[31:22] == OP_ST_W) begin
      // address uses the immediate; the second port reads rd as store data
      src2_is_imm   = 1'b1;
      src_reg_is_rd = 1'b1;
      mem_we        = 1'b1;
    end else if (ir[31:26] == OP_BEQ) begin
      src_reg_is_rd = 1'b1;
      br_type       = BR_EQ;
    end else if (ir[31:26] == OP_BNE) begin
      src_reg_is_rd = 1'b1;
      br_type       = BR_NE;
    end else if (ir[31:26] == OP_B) begin
      br_type = BR_B;
    end else begin
      illegal = 1'b1;
    end
  end

endmodule

// File: rtl/minicpu_regfile.sv
// minicpu_regfile: 32x32 register file, two async read ports, one write port.
// Latency: reads combinational, write visible the cycle after we.
// Backpressure: none.
module minicpu_regfile (
  input  logic        clk,
  input  logic [4:0]  raddr1,
  output logic [31:0] rdata1,
  input  logic [4:0]  raddr2,
  output logic [31:0] rdata2,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata
);

  logic [31:0] regs [32];

  // Write port; r0 is never written so it stays a hard zero on reads
  always_ff @(posedge clk) begin
    if (we && (waddr != 5'd0)) begin
      regs[waddr] <= wdata;
    end
  end

  // Read ports with r0 forced to zero
  always_comb begin
    rdata1 = (raddr1 == 5'd0) ? 32'd0 : regs[raddr1];
    rdata2 = (raddr2 == 5'd0) ? 32'd0 : regs[raddr2];
  end

endmodule

// File: rtl/minicpu_mc.sv
// minicpu_mc: multi-cycle LoongArch32-subset core with req/resp memory ports.
// Latency: 3 cycles/insn (ALU, branch), 4 (ld/st) with zero-wait memories.
// Backpressure: holds inst_req/data_req until the matching resp; one outstanding each.
module minicpu_mc
  import minicpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC        = RESET_PC_DEF,
  parameter bit          ALIGN_CHECK     = 1'b1,
  parameter bit          HALT_ON_ILLEGAL = 1'b1
) (
  input  logic        clk,
  input  logic        resetn,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic        inst_resp,
  input  logic [31:0] inst_rdata,
  output logic        data_req,
  output logic        data_we,
  output logic [31:0] data_addr,
  output logic [31:0] data_wdata,
  input  logic        data_resp,
  input  logic [31:0] data_rdata,
  output logic        halted,
  output logic [31:0] debug_wb_pc,
  output logic        debug_wb_rf_we,
  output logic [4:0]  debug_wb_rf_wnum,
  output logic [31:0] debug_wb_rf_wdata
);

  state_e      state, state_nxt;
  logic        run;
  logic [31:0] pc, ir;
  logic [31:0] res_r, nextpc_r, addr_r, wdata_r;
  logic [4:0]  wnum_r;
  logic        we_r, st_r, ld_r;

  alu_op_e     alu_op;
  br_type_e    br_type;
  logic        src2_is_imm, src_reg_is_rd, gr_we, mem_rd, mem_we, illegal;

  logic [4:0]  rd, rj, rk;
  logic [31:0] rf_r1, rf_r2, imm, src2, alu_res;
  logic [31:0] br_offs, br_target, ex_nextpc;
  logic        br_taken, mem_op, misalign, ex_halt;

  assign rd = ir[4:0];
  assign rj = ir[9:5];
  assign rk = ir[14:10];

  minicpu_decoder u_dec (
    .ir            (ir),
    .alu_op        (alu_op),
    .src2_is_imm   (src2_is_imm),
    .src_reg_is_rd (src_reg_is_rd),
    .gr_we         (gr_we),
    .mem_rd        (mem_rd),
    .mem_we        (mem_we),
    .br_type       (br_type),
    .illegal       (illegal)
  );

  minicpu_regfile u_rf (
    .clk    (clk),
    .raddr1 (rj),
    .rdata1 (rf_r1),
    .raddr2 (src_reg_is_rd ? rd : rk),
    .rdata2 (rf_r2),
    .we     (debug_wb_rf_we),
    .waddr  (debug_wb_rf_wnum),
    .wdata  (debug_wb_rf_wdata)
  );

  // EX datapath: operand select, ALU, branch resolution and halt detection
  always_comb begin
    imm  = (alu_op == ALU_LUI) ? {ir[24:5], 12'b0} : sext12(ir[21:10]);
    src2 = src2_is_imm ? imm : rf_r2;
    case (alu_op)
      ALU_SUB: alu_res = rf_r1 - src2;
      ALU_LUI: alu_res = src2;
      default: alu_res = rf_r1 + src2;
    endcase
    br_offs = (br_type == BR_B) ? {{4{ir[9]}}, ir[9:0], ir[25:10], 2'b00}
                                : {{14{ir[25]}}, ir[25:10], 2'b00};
    br_target = pc + br_offs;
    case (br_type)
      BR_EQ:   br_taken = (rf_r1 == rf_r2);
      BR_NE:   br_taken = (rf_r1 != rf_r2);
      BR_B:    br_taken = 1'b1;
      default: br_taken = 1'b0;
    endcase
    ex_nextpc = br_taken ? br_target : pc + 32'd4;
    mem_op    = mem_rd | mem_we;
    misalign  = ALIGN_CHECK && ((mem_op && (alu_res[1:0] != 2'b00)) ||
                                (br_taken && (br_target[1:0] != 2'b00)));
    ex_halt   = misalign || (illegal && HALT_ON_ILLEGAL);
  end

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= S_IF;
    else         state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IF:    if (run && inst_resp) state_nxt = S_EX;
      S_EX: begin
        if (ex_halt)     state_nxt = S_HALT;
        else if (mem_op) state_nxt = S_MEM;
        else             state_nxt = S_WB;
      end
      S_MEM:   if (data_resp) state_nxt = S_WB;
      S_WB:    state_nxt = S_IF;
      S_HALT:  state_nxt = S_HALT;
      default: state_nxt = S_HALT;
    endcase
  end

  // Output logic: requests, halt flag and the one-cycle retire port
  always_comb begin
    inst_req          = (state == S_IF) && run;
    inst_addr         = pc;
    data_req          = (state == S_MEM);
    data_we           = data_req && st_r;
    data_addr         = data_req ? {addr_r[31:2], 2'b00} : 32'd0;
    data_wdata        = data_req ? wdata_r : 32'd0;
    halted            = (state == S_HALT);
    debug_wb_pc       = (state == S_WB) ? pc : 32'd0;
    debug_wb_rf_we    = (state == S_WB) && we_r && (wnum_r != 5'd0);
    debug_wb_rf_wnum  = debug_wb_rf_we ? wnum_r : 5'd0;
    debug_wb_rf_wdata = debug_wb_rf_we ? res_r : 32'd0;
  end

  // Datapath registers: IR capture, EX results, load data, pc update.
  // run keeps inst_req low until the first edge after reset release.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      run      <= 1'b0;
      pc       <= RESET_PC;
      ir       <= 32'd0;
      res_r    <= 32'd0;
      nextpc_r <= 32'd0;
      addr_r   <= 32'd0;
      wdata_r  <= 32'd0;
      wnum_r   <= 5'd0;
      we_r     <= 1'b0;
      st_r     <= 1'b0;
      ld_r     <= 1'b0;
    end else begin
      run <= 1'b1;
      case (state)
        S_IF: if (run && inst_resp) ir <= inst_rdata;
        S_EX: begin
          res_r    <= alu_res;
          nextpc_r <= ex_nextpc;
          addr_r   <= alu_res;
          wdata_r  <= rf_r2;
          wnum_r   <= rd;
          we_r     <= gr_we;
          st_r     <= mem_we;
          ld_r     <= mem_rd;
        end
        S_MEM: if (data_resp && ld_r) res_r <= data_rdata;
        S_WB:  pc <= nextpc_r;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_minicpu_mc.sv
// tb_minicpu_mc: directed programs with retire and data-port scoreboards.
// Latency: memory models respond after ilat/dlat cycles (0 = same cycle).
// Backpressure: models hold responses until their latency expires.
module tb_minicpu_mc;

  localparam logic [31:0] RPC = 32'h1c000000;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        inst_req, inst_resp;
  logic [31:0] inst_addr, inst_rdata;
  logic        data_req, data_we, data_resp;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic        halted, debug_wb_rf_we;
  logic [31:0] debug_wb_pc, debug_wb_rf_wdata;
  logic [4:0]  debug_wb_rf_wnum;

  minicpu_mc dut (
    .clk               (clk),
    .resetn            (resetn),
    .inst_req          (inst_req),
    .inst_addr         (inst_addr),
    .inst_resp         (inst_resp),
    .inst_rdata        (inst_rdata),
    .data_req          (data_req),
    .data_we           (data_we),
    .data_addr         (data_addr),
    .data_wdata        (data_wdata),
    .data_resp         (data_resp),
    .data_rdata        (data_rdata),
    .halted            (halted),
    .debug_wb_pc       (debug_wb_pc),
    .debug_wb_rf_we    (debug_wb_rf_we),
    .debug_wb_rf_wnum  (debug_wb_rf_wnum),
    .debug_wb_rf_wdata (debug_wb_rf_wdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic        we;
    logic [4:0]  wnum;
    logic [31:0] wdata;
    int          gap;
  } ret_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          len;
  } dtx_t;

  ret_t        rq[$];
  dtx_t        dq[$];
  logic [31:0] imem [64];
  logic [31:0] dmem [logic [31:0]];
  int          errors = 0;
  int          checks = 0;
  int          ilat = 0, dlat = 0;
  int          cyc = 0, last_ret_cyc = 0;
  int          dreq_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_ret(input logic [31:0] pc, input logic we, input logic [4:0] wnum,
                          input logic [31:0] wdata, input int gap);
    ret_t r;
    r.pc = pc; r.we = we; r.wnum = wnum; r.wdata = wdata; r.gap = gap;
    rq.push_back(r);
  endtask

  task automatic push_dtx(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input int len);
    dtx_t d;
    d.we = we; d.addr = addr; d.wdata = wdata; d.len = len;
    dq.push_back(d);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Instruction memory: answers after ilat extra cycles, same cycle when ilat=0
  always @(negedge clk) begin : imem_model
    static int icnt = 0;
    if (resetn && inst_req) begin
      if (icnt >= ilat) begin
        inst_resp  = 1'b1;
        inst_rdata = (inst_addr - RPC < 32'd256) ? imem[(inst_addr - RPC) >> 2] : 32'hffffffff;
        icnt = 0;
      end else begin
        inst_resp = 1'b0;
        icnt++;
      end
    end else begin
      inst_resp = 1'b0;
      icnt = 0;
    end
  end

  // Data memory and data-port monitor: checks direction, address, data, hold time
  always @(negedge clk) begin : dmem_model
    static int          len = 0;
    static logic [31:0] a0 = 32'd0;
    static logic        unstable = 1'b0;
    dtx_t d;
    data_resp = 1'b0;
    if (resetn && data_req) begin
      dreq_total++;
      if (len == 0) begin
        a0 = data_addr;
        unstable = 1'b0;
      end else if (data_addr !== a0) begin
        unstable = 1'b1;
      end
      len++;
      if (len > dlat) begin
        data_resp = 1'b1;
        if (data_we) dmem[data_addr] = data_wdata;
        else data_rdata = dmem.exists(data_addr) ? dmem[data_addr] : 32'd0;
        if (dq.size() == 0) begin
          chk("unexpected_data_req", 32'd1, 32'd0);
        end else begin
          d = dq.pop_front();
          chk("data_we", {31'd0, data_we}, {31'd0, d.we});
          chk("data_addr", data_addr, d.addr);
          if (d.we) chk("data_wdata", data_wdata, d.wdata);
          chk("data_req_len", len, d.len);
          chk("data_addr_stable", {31'd0, unstable}, 32'd0);
        end
        len = 0;
      end
    end else begin
      len = 0;
    end
  end

  // Retire monitor: pops one expectation per WB cycle
  always @(negedge clk) begin : retire_mon
    ret_t r;
    if (resetn && debug_wb_pc != 32'd0) begin
      if (rq.size() == 0) begin
        chk("unexpected_retire", debug_wb_pc, 32'd0);
      end else begin
        r = rq.pop_front();
        chk("wb_pc", debug_wb_pc, r.pc);
        chk("wb_we", {31'd0, debug_wb_rf_we}, {31'd0, r.we});
        if (r.we) begin
          chk("wb_wnum", {27'd0, debug_wb_rf_wnum}, {27'd0, r.wnum});
          chk("wb_wdata", debug_wb_rf_wdata, r.wdata);
        end
        if (r.gap != 0) chk("wb_cycles", cyc - last_ret_cyc, r.gap);
      end
      last_ret_cyc = cyc;
    end
  end

  task automatic wait_retired(input int bound);
    int n = 0;
    while (rq.size() != 0 && n < bound) begin
      @(negedge clk);
      n++;
    end
    chk("retire_timeout", rq.size(), 32'd0);
  endtask

  task automatic wait_halted(input int bound);
    int n = 0;
    while (!halted && n < bound) begin
      @(negedge clk);
      n++;
    end
    chk("halted", {31'd0, halted}, 32'd1);
  endtask

  task automatic release_and_check();
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk);
    #1;
    chk("first_inst_req", {31'd0, inst_req}, 32'd1);
    chk("first_inst_addr", inst_addr, RPC);
  endtask

  initial begin
    int n;
    for (int i = 0; i < 64; i++) imem[i] = 32'hffffffff;
    inst_resp = 1'b0; inst_rdata = 32'd0; data_resp = 1'b0; data_rdata = 32'd0;

    // Program 1: ALU, store/load, countdown loop, lu12i, beq, b, illegal
    imem[0]  = 32'h02801401; // addi.w r1,r0,5
    imem[1]  = 32'h00100422; // add.w  r2,r1,r1
    imem[2]  = 32'h00110803; // sub.w  r3,r0,r2
    imem[3]  = 32'h29840002; // st.w   r2,r0,0x100
    imem[4]  = 32'h28840004; // ld.w   r4,r0,0x100
    imem[5]  = 32'h02800C01; // addi.w r1,r0,3
    imem[6]  = 32'h02BFFC21; // addi.w r1,r1,-1
    imem[7]  = 32'h5FFFFC20; // bne    r1,r0,-1
    imem[8]  = 32'h142468A5; // lu12i.w r5,0x12345
    imem[9]  = 32'h58000800; // beq    r0,r0,+2
    imem[10] = 32'h02800406; // addi.w r6,r0,1 (skipped)
    imem[11] = 32'h50000800; // b      +2
    imem[12] = 32'h02800407; // addi.w r7,r0,1 (skipped)
    imem[13] = 32'hffffffff; // illegal
    dmem[32'h100] = 32'd0;
    ilat = 0;
    dlat = 3;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_inst_req", {31'd0, inst_req}, 32'd0);
    chk("rst_inst_addr", inst_addr, RPC);
    chk("rst_data_req", {31'd0, data_req}, 32'd0);
    chk("rst_halted", {31'd0, halted}, 32'd0);
    chk("rst_wb_pc", debug_wb_pc, 32'd0);
    chk("rst_wb_we", {31'd0, debug_wb_rf_we}, 32'd0);

    push_ret(RPC + 32'h00, 1, 1, 32'd5, 0);
    push_ret(RPC + 32'h04, 1, 2, 32'd10, 3);
    push_ret(RPC + 32'h08, 1, 3, 32'hfffffff6, 3);
    push_ret(RPC + 32'h0c, 0, 0, 32'd0, 7);
    push_ret(RPC + 32'h10, 1, 4, 32'd10, 7);
    push_ret(RPC + 32'h14, 1, 1, 32'd3, 3);
    push_ret(RPC + 32'h18, 1, 1, 32'd2, 3);
    push_ret(RPC + 32'h1c, 0, 0, 32'd0, 3);
    push_ret(RPC + 32'h18, 1, 1, 32'd1, 3);
    push_ret(RPC + 32'h1c, 0, 0, 32'd0, 3);
    push_ret(RPC + 32'h18, 1, 1, 32'd0, 3);
    push_ret(RPC + 32'h1c, 0, 0, 32'd0, 3);
    push_ret(RPC + 32'h20, 1, 5, 32'h12345000, 3);
    push_ret(RPC + 32'h24, 0, 0, 32'd0, 3);
    push_ret(RPC + 32'h2c, 0, 0, 32'd0, 3);
    push_dtx(1, 32'h100, 32'd10, 4);
    push_dtx(0, 32'h100, 32'd0, 4);

    release_and_check();
    wait_retired(400);
    wait_halted(50);
    chk("halt_after_ex", cyc - last_ret_cyc, 32'd3);
    n = 0;
    repeat (10) begin
      @(negedge clk);
      if (inst_req) n++;
    end
    chk("no_fetch_when_halted", n, 32'd0);
    chk("data_queue_drained", dq.size(), 32'd0);

    // Program 2: misaligned load halts without touching the data port
    resetn = 1'b0;
    imem[0] = 32'h28840804;  // ld.w r4,r0,0x102
    dlat = 0;
    repeat (2) @(negedge clk);
    dreq_total = 0;
    release_and_check();
    wait_halted(50);
    repeat (3) @(negedge clk);
    chk("misalign_no_data_req", dreq_total, 32'd0);

    // Program 3: reset during MEM abandons the load
    resetn = 1'b0;
    imem[0] = 32'h28840004;  // ld.w r4,r0,0x100
    imem[1] = 32'hffffffff;
    dmem[32'h100] = 32'h55;
    dlat = 50;
    ilat = 1;
    repeat (2) @(negedge clk);
    release_and_check();
    n = 0;
    while (!data_req && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("mem_reached", {31'd0, data_req}, 32'd1);
    @(posedge clk);
    #3;
    resetn = 1'b0;
    #1;
    chk("abort_data_req", {31'd0, data_req}, 32'd0);
    chk("abort_inst_req", {31'd0, inst_req}, 32'd0);
    chk("abort_inst_addr", inst_addr, RPC);
    imem[0] = 32'h00100085;  // add.w r5,r4,r0 : r4 must still be 10
    dlat = 0;
    push_ret(RPC, 1, 5, 32'd10, 0);
    repeat (2) @(negedge clk);
    release_and_check();
    wait_retired(100);
    wait_halted(50);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global watchdog so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/minicpu_mc.md
Name: minicpu_mc

Overview:
- Parametrised multi-cycle successor to the single-cycle miniCPU core. Executes a LoongArch32 subset.
- Talks to instruction and data memories over variable-latency request/response handshakes, instead of zero-latency SRAM ports.
- Adds sub.w, lu12i.w, beq, b, misalignment and illegal-instruction halting, and a retire/debug port for trace comparison.
- Sits at the top of the miniCPU SoC, between the bus bridge and the register file.

Parameters:
- RESET_PC, 32'h1c000000, PC value loaded on reset.
- ALIGN_CHECK, 1, when 1: misaligned ld.w/st.w address or misaligned branch target halts the core.
- HALT_ON_ILLEGAL, 1, when 1: undecodable instruction halts; when 0: it retires as a NOP.

Ports:
- clk  in  1  core clock, rising edge.
- resetn  in  1  asynchronous active-low reset.
- inst_req  out  1  instruction fetch request, held until inst_resp.
- inst_addr  out  32  fetch address (= pc), stable while inst_req.
- inst_resp  in  1  fetch response valid; ends the transaction.
- inst_rdata  in  32  instruction word, valid with inst_resp.
- data_req  out  1  data request, held until data_resp.
- data_we  out  1  1 = store, 0 = load; stable while data_req.
- data_addr  out  32  byte address, word aligned.
- data_wdata  out  32  store data.
- data_resp  in  1  data response; completes both loads and stores.
- data_rdata  in  32  load data, valid with data_resp.
- halted  out  1  sticky, core stopped.
- debug_wb_pc  out  32  pc of the retiring instruction.
- debug_wb_rf_we  out  1  register write this cycle.
- debug_wb_rf_wnum  out  5  destination register.
- debug_wb_rf_wdata  out  32  written value.

Behaviour:
- Reset (async assert, sync release): pc=RESET_PC, state=IF. All outputs 0 except inst_addr=RESET_PC. Requests drop immediately; memories must tolerate abandoned transactions.
- FSM states: IF, EX, MEM, WB, HALT. One transaction outstanding per interface.
- IF: inst_req=1. When inst_resp=1, latch inst_rdata into IR, go to EX. A response arriving in the same cycle as the request is legal.
- EX: one cycle. Decode, read regfile (rj; rk or rd), compute ALU result and branch. ld/st go to MEM; everything else goes to WB. Misaligned or illegal instruction goes to HALT (per parameters).
- MEM: data_req=1 with data_addr = rj+sext(si12). When data_resp=1, latch data_rdata, go to WB.
- WB: one cycle. Regfile write if gr_we && rd!=0. debug_wb_* valid for exactly this cycle; debug_wb_rf_we=0 for st/branch/rd=0. pc<=nextpc, go to IF.
- HALT: absorbing until reset. halted=1, no requests, no retire.
- Minimum CPI with zero-wait memories: 3 (ALU/branch), 4 (ld/st).
- Decode (IR bits):
  - add.w: [31:15]=0x00020.
  - sub.w: [31:15]=0x00022.
  - addi.w: [31:22]=0x00A.
  - lu12i.w: [31:25]=0x0A, result {si20,12'b0}.
  - ld.w: [31:22]=0x0A2.
  - st.w: [31:22]=0x0A6, data = rd value.
  - beq: [31:26]=0x16. bne: [31:26]=0x17.
  - b: [31:26]=0x14, offs = sext({[9:0],[25:10]},2'b0).
- Immediates:
  - si12 = sext(IR[21:10]).
  - beq/bne offset = sext(IR[25:10])<<2.
  - Targets are relative to the pc of the branch.
- Arithmetic: 32-bit wrap-around, no overflow trap.
- r0 reads 0 and writes to it are discarded.
- Halt vs. memory: a halt detected in EX issues no data_req. ALIGN_CHECK applies to data_addr[1:0] and to branch target[1:0].

Decomposition:
- Package minicpu_pkg:
  - state enum.
  - opcode field constants (values above).
  - ALU op enum: ADD, SUB, LUI.
  - RESET_PC default.
- Sub-module minicpu_decoder (combinational): IR -> control bundle (alu_op, src2_is_imm, src_reg_is_rd, gr_we, mem_rd, mem_we, br_type, illegal).
- Existing regfile reused unchanged.

Test Plan:
- Reset release, zero-wait memories -> first inst_req=1 with inst_addr=0x1c000000 in the cycle after reset deasserts. No debug retire before the first WB.
- addi.w r1,r0,5; add.w r2,r1,r1; sub.w r3,r0,r2 -> retires (r1,5), (r2,10), (r3,0xfffffff6); 3 cycles each.
- st.w r2,r0,0x100; ld.w r4,r0,0x100 with data_resp delayed 3 cycles -> data_req held 4 cycles with address stable; ld retires (r4,10); st retires with rf_we=0.
- Loop: addi.w r1,r1,-1 followed by bne r1,r0,-1 (r1=3) -> bne taken twice to the addi pc, third bne falls through to pc+4; pc trace matches.
- Word 0xffffffff fetched -> halted=1 in the cycle after EX; no further inst_req. ld.w at address 0x102 -> HALT with no data_req.
- resetn pulsed low mid-MEM -> data_req drops asynchronously; after release, fetch restarts at 0x1c000000 and regfile writes from the aborted instruction are absent.
